intc_trap_ctrl: RTL and testbench
=================================

Name: intc_trap_ctrl

Overview:
- Trap sequencer for the single-hart core. Detects synchronous exceptions (ecall/ebreak) in EX, mret, and external/timer interrupts.
- Stalls the pipeline, then writes mepc, mstatus and mcause through the CSR file's intc write port, one CSR per cycle.
- Finally redirects fetch to the trap vector (mtvec) or, for mret, to mepc.

Parameters:
- RESET_ADDR, 32'h0000_0000, int_addr_o value held while idle and after reset.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- inst_addr_i  in  32  PC of instruction currently in EX
- ecall_i  in  1  EX holds ecall
- ebreak_i  in  1  EX holds ebreak
- mret_i  in  1  EX holds mret
- ex_jump_i  in  1  EX branch/jump taken this cycle
- ex_jump_addr_i  in  32  its target
- irq_ext_i  in  1  external interrupt, level
- irq_timer_i  in  1  timer interrupt, level
- csr_mtvec_i  in  32  current mtvec
- csr_mepc_i  in  32  current mepc
- csr_mstatus_i  in  32  current mstatus
- csr_intc_addr_o  out  12  CSR write address
- csr_intc_data_o  out  32  CSR write data
- csr_intc_we_o  out  1  CSR write enable
- hold_flag_o  out  1  pipeline stall request
- int_jump_o  out  1  one-cycle redirect strobe
- int_addr_o  out  32  redirect target
- irq_ack_o  out  1  one-cycle pulse when an interrupt is accepted

Behaviour:
- Reset (async, rst_n=0):
  - FSM goes to IDLE.
  - csr_intc_we_o=0, csr_intc_addr_o=0, csr_intc_data_o=0, int_jump_o=0, irq_ack_o=0, int_addr_o=RESET_ADDR.
  - All latched fields cleared.
  - Reset mid-sequence aborts it; partial CSR writes already done are not undone.
- FSM states: IDLE, W_MEPC, W_MSTATUS, W_MCAUSE, MRET_ST, JUMP. All outputs registered except hold_flag_o.
- IDLE request priority: ecall > ebreak > mret > irq_ext > irq_timer.
  - Interrupts are eligible only when csr_mstatus_i[3] (MIE) = 1.
  - Exceptions and mret are taken regardless of MIE.
- On accept in IDLE (cycle 0), latch:
  - cause: ecall=32'd11, ebreak=32'd3, ext=32'h8000_000B, timer=32'h8000_0007.
  - mstatus snapshot = csr_mstatus_i.
  - mepc:
    - exceptions: inst_addr_i.
    - interrupts: ex_jump_addr_i if ex_jump_i else inst_addr_i. The EX instruction is squashed and re-executed.
  - irq_ack_o pulses in cycle 1 for interrupts only.
- Trap path, one write per cycle:
  - W_MEPC (cycle 1): we=1, addr=12'h341, data=latched mepc.
  - W_MSTATUS (cycle 2): we=1, addr=12'h300, data=snapshot with bit7(MPIE)=snapshot[3] and bit3(MIE)=0.
  - W_MCAUSE (cycle 3): we=1, addr=12'h342, data=cause.
  - JUMP (cycle 4): we=0, int_jump_o=1, int_addr_o={csr_mtvec_i[31:2],2'b00}. Then IDLE.
- mret path:
  - MRET_ST (cycle 1): we=1, addr=12'h300, data=snapshot with bit3=snapshot[7] and bit7=1.
  - JUMP (cycle 2): int_jump_o=1, int_addr_o=csr_mepc_i. Then IDLE.
- hold_flag_o = (state != IDLE) | (IDLE & request accepted this cycle). Combinational, so EX CSR writes are suppressed for the whole sequence and the intc port never collides with the EX port.
- Requests arriving while not IDLE are ignored. A level irq still asserted on return to IDLE is re-evaluated; MIE is then 0 unless software re-enabled it.
- An irq deasserted mid-sequence does not abort the sequence.
- int_addr_o holds its last value when int_jump_o=0.

Optional Feature:
- Macro INTC_VECTORED_EN.
- Defined: if csr_mtvec_i[1:0]==2'b01 and the trap is an interrupt, JUMP target = {csr_mtvec_i[31:2],2'b00} + (cause[3:0] << 2). Exceptions always use the base address.
- Undefined: mtvec[1:0] is ignored; all traps jump to {csr_mtvec_i[31:2],2'b00}.

Test Plan:
- Reset asserted mid-W_MSTATUS -> outputs return to reset values immediately, FSM IDLE, no further CSR writes.
- ecall at inst_addr_i=32'h100, mstatus=32'h8, mtvec=32'h200 -> writes in order: 341<=0x100, 300<=0x80, 342<=11; cycle 4 int_jump_o=1, int_addr_o=0x200; hold high for cycles 0-4.
- irq_timer with MIE=0 -> no response; set MIE=1 -> mcause=0x80000007, irq_ack_o pulses once.
- irq_ext coincident with ex_jump_i=1, ex_jump_addr_i=32'h400 -> mepc written 0x400, mcause=0x8000000B.
- ecall and irq_ext asserted together -> ecall wins (mcause=11); irq taken later only after MIE re-set.
- mret with mstatus=32'h80, mepc=32'h104 -> 300<=0x88, jump to 0x104 in cycle 2. With INTC_VECTORED_EN and mtvec=0x201, a timer irq jumps to 0x21C.

Source files
------------

// File: rtl/intc_trap_ctrl.sv
// Trap sequencer: detects ecall/ebreak/mret/interrupts in IDLE, stalls the pipeline,
// writes mepc/mstatus/mcause one CSR per cycle, then redirects fetch.
// Latency: trap = accept cycle + 3 CSR writes + jump (5 cycles); mret = accept + 1 write + jump (3 cycles).
// Backpressure: none consumed; hold_flag_o stalls the pipeline combinationally for the whole sequence.
//
// Ports: clk/rst_n (async active-low); EX-stage request inputs (inst_addr_i, ecall_i, ebreak_i,
// mret_i, ex_jump_i, ex_jump_addr_i); level interrupts irq_ext_i/irq_timer_i; CSR reads csr_mtvec_i,
// csr_mepc_i, csr_mstatus_i; CSR write port csr_intc_*; hold_flag_o, int_jump_o/int_addr_o redirect,
// irq_ack_o accept pulse.
// Optional build macro INTC_VECTORED_EN: vectored interrupt targets when mtvec[1:0] == 2'b01.
module intc_trap_ctrl #(
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] inst_addr_i,
    input  logic        ecall_i,
    input  logic        ebreak_i,
    input  logic        mret_i,
    input  logic        ex_jump_i,
    input  logic [31:0] ex_jump_addr_i,
    input  logic        irq_ext_i,
    input  logic        irq_timer_i,
    input  logic [31:0] csr_mtvec_i,
    input  logic [31:0] csr_mepc_i,
    input  logic [31:0] csr_mstatus_i,
    output logic [11:0] csr_intc_addr_o,
    output logic [31:0] csr_intc_data_o,
    output logic        csr_intc_we_o,
    output logic        hold_flag_o,
    output logic        int_jump_o,
    output logic [31:0] int_addr_o,
    output logic        irq_ack_o
);

    typedef enum logic [2:0] {
        IDLE, W_MEPC, W_MSTATUS, W_MCAUSE, MRET_ST, JUMP
    } state_t;

    state_t state, state_nxt;

    // Fields captured at accept time
    logic [31:0] cause_q, mstatus_q, mepc_q;
    logic        irq_q, mret_q;

    // Request decode (only meaningful in IDLE)
    logic        mie, exc_req, mret_req, ext_req, timer_req, irq_req, accept;
    logic [31:0] cause_req, mepc_req;

    assign mie       = csr_mstatus_i[3];
    assign exc_req   = ecall_i | ebreak_i;
    assign mret_req  = mret_i & ~exc_req;
    assign ext_req   = irq_ext_i & mie & ~exc_req & ~mret_i;
    assign timer_req = irq_timer_i & mie & ~exc_req & ~mret_i & ~irq_ext_i;
    assign irq_req   = ext_req | timer_req;
    assign accept    = (state == IDLE) & (exc_req | mret_i | irq_req);

    assign cause_req = ecall_i  ? 32'd11 :
                       ebreak_i ? 32'd3 :
                       ext_req  ? 32'h8000_000B : 32'h8000_0007;

    // An interrupted instruction is squashed; resume at the taken branch target if any.
    assign mepc_req = (irq_req & ex_jump_i) ? ex_jump_addr_i : inst_addr_i;

    // Trap target
    logic [31:0] trap_base, trap_tgt;
    assign trap_base = {csr_mtvec_i[31:2], 2'b00};
`ifdef INTC_VECTORED_EN
    assign trap_tgt = (irq_q && csr_mtvec_i[1:0] == 2'b01)
                    ? trap_base + {26'd0, cause_q[3:0], 2'b00} : trap_base;
`else
    logic unused_mode;
    assign unused_mode = ^{csr_mtvec_i[1:0], irq_q};
    assign trap_tgt    = trap_base;
`endif

    // Registered-output next values
    logic        we_nxt, jump_nxt, ack_nxt;
    logic [11:0] addr_nxt;
    logic [31:0] data_nxt, iaddr_nxt;

    always_comb begin
        state_nxt = state;
        we_nxt    = 1'b0;
        addr_nxt  = 12'h000;
        data_nxt  = 32'h0;
        jump_nxt  = 1'b0;
        ack_nxt   = 1'b0;
        iaddr_nxt = int_addr_o;
        case (state)
            IDLE: begin
                if (accept) begin
                    we_nxt = 1'b1;
                    if (mret_req) begin
                        // mret: MIE <= MPIE, MPIE <= 1
                        state_nxt = MRET_ST;
                        addr_nxt  = 12'h300;
                        data_nxt  = {csr_mstatus_i[31:8], 1'b1, csr_mstatus_i[6:4],
                                     csr_mstatus_i[7], csr_mstatus_i[2:0]};
                    end else begin
                        state_nxt = W_MEPC;
                        addr_nxt  = 12'h341;
                        data_nxt  = mepc_req;
                        ack_nxt   = irq_req;
                    end
                end
            end
            W_MEPC: begin
                // trap entry: MPIE <= MIE, MIE <= 0
                state_nxt = W_MSTATUS;
                we_nxt    = 1'b1;
                addr_nxt  = 12'h300;
                data_nxt  = {mstatus_q[31:8], mstatus_q[3], mstatus_q[6:4], 1'b0, mstatus_q[2:0]};
            end
            W_MSTATUS: begin
                state_nxt = W_MCAUSE;
                we_nxt    = 1'b1;
                addr_nxt  = 12'h342;
                data_nxt  = cause_q;
            end
            W_MCAUSE, MRET_ST: begin
                state_nxt = JUMP;
                jump_nxt  = 1'b1;
                iaddr_nxt = mret_q ? csr_mepc_i : trap_tgt;
            end
            JUMP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign hold_flag_o = (state != IDLE) | accept;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            csr_intc_we_o   <= 1'b0;
            csr_intc_addr_o <= 12'h000;
            csr_intc_data_o <= 32'h0;
            int_jump_o      <= 1'b0;
            irq_ack_o       <= 1'b0;
            int_addr_o      <= RESET_ADDR;
            cause_q         <= 32'h0;
            mstatus_q       <= 32'h0;
            mepc_q          <= 32'h0;
            irq_q           <= 1'b0;
            mret_q          <= 1'b0;
        end else begin
            csr_intc_we_o   <= we_nxt;
            csr_intc_addr_o <= addr_nxt;
            csr_intc_data_o <= data_nxt;
            int_jump_o      <= jump_nxt;
            irq_ack_o       <= ack_nxt;
            int_addr_o      <= iaddr_nxt;
            if (accept) begin
                cause_q   <= cause_req;
                mstatus_q <= csr_mstatus_i;
                mepc_q    <= mepc_req;
                irq_q     <= irq_req;
                mret_q    <= mret_req;
            end
        end
    end

endmodule

// File: tb/tb_intc_trap_ctrl.sv
// Testbench for intc_trap_ctrl: directed scenarios plus randomized requests checked
// against a reference model of the trap rules; a small CSR mirror feeds mstatus/mepc back.
// Prints one summary line of passed/total checks.
module tb_intc_trap_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] inst_addr_i, ex_jump_addr_i, csr_mtvec_i;
    logic        ecall_i, ebreak_i, mret_i, ex_jump_i, irq_ext_i, irq_timer_i;
    logic [31:0] csr_mepc_i = 32'h0;
    logic [31:0] csr_mstatus_i = 32'h0;
    logic [11:0] csr_intc_addr_o;
    logic [31:0] csr_intc_data_o, int_addr_o;
    logic        csr_intc_we_o, hold_flag_o, int_jump_o, irq_ack_o;

    intc_trap_ctrl dut (
        .clk(clk), .rst_n(rst_n), .inst_addr_i(inst_addr_i), .ecall_i(ecall_i),
        .ebreak_i(ebreak_i), .mret_i(mret_i), .ex_jump_i(ex_jump_i),
        .ex_jump_addr_i(ex_jump_addr_i), .irq_ext_i(irq_ext_i), .irq_timer_i(irq_timer_i),
        .csr_mtvec_i(csr_mtvec_i), .csr_mepc_i(csr_mepc_i), .csr_mstatus_i(csr_mstatus_i),
        .csr_intc_addr_o(csr_intc_addr_o), .csr_intc_data_o(csr_intc_data_o),
        .csr_intc_we_o(csr_intc_we_o), .hold_flag_o(hold_flag_o), .int_jump_o(int_jump_o),
        .int_addr_o(int_addr_o), .irq_ack_o(irq_ack_o)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    // CSR mirror: software writes from the bench, otherwise the intc write port
    logic        sw_we = 1'b0;
    logic [11:0] sw_addr = 12'h0;
    logic [31:0] sw_val = 32'h0;
    always @(posedge clk) begin
        if (sw_we) begin
            if (sw_addr == 12'h300) csr_mstatus_i <= sw_val;
            else                    csr_mepc_i    <= sw_val;
        end else if (csr_intc_we_o) begin
            if (csr_intc_addr_o == 12'h300) csr_mstatus_i <= csr_intc_data_o;
            if (csr_intc_addr_o == 12'h341) csr_mepc_i    <= csr_intc_data_o;
        end
    end

    task automatic sw_write(input logic [11:0] a, input logic [31:0] v);
        sw_addr = a; sw_val = v; sw_we = 1'b1;
        @(posedge clk); #1;
        sw_we = 1'b0;
    endtask

    // Observations from one sequence
    bit          hold0;
    int          n_hold, n_ack, n_jump, jump_cyc;
    logic [31:0] jump_addr;
    logic [43:0] wr_q[$];

    function automatic logic [43:0] wr_at(input int i);
        if (i < wr_q.size()) return wr_q[i];
        return 44'hfff_ffff_ffff;
    endfunction

    task automatic run_seq(input bit ec, eb, mr, ext, tmr, jmp,
                           input logic [31:0] ia, ja, input bit keep);
        wr_q.delete();
        n_hold = 0; n_ack = 0; n_jump = 0; jump_cyc = -1; jump_addr = 32'h0;
        @(posedge clk); #1;
        ecall_i = ec; ebreak_i = eb; mret_i = mr; irq_ext_i = ext; irq_timer_i = tmr;
        ex_jump_i = jmp; inst_addr_i = ia; ex_jump_addr_i = ja;
        @(negedge clk);
        hold0 = hold_flag_o;
        if (hold_flag_o) n_hold++;
        @(posedge clk); #1;
        ecall_i = 0; ebreak_i = 0; mret_i = 0; ex_jump_i = 0;
        if (!keep) begin irq_ext_i = 0; irq_timer_i = 0; end
        for (int c = 1; c < 8; c++) begin
            @(negedge clk);
            if (csr_intc_we_o) wr_q.push_back({csr_intc_addr_o, csr_intc_data_o});
            if (hold_flag_o) n_hold++;
            if (irq_ack_o) n_ack++;
            if (int_jump_o) begin n_jump++; jump_cyc = c; jump_addr = int_addr_o; end
        end
        irq_ext_i = 0; irq_timer_i = 0;
    endtask

    // Reference model of the trap rules
    logic [43:0] exp_q[$];
    int          exp_jump, exp_cyc, exp_hold, exp_ack;
    logic [31:0] exp_addr;

    task automatic model(input bit ec, eb, mr, ext, tmr, jmp,
                         input logic [31:0] ia, ja, ms, mepc, mtv);
        logic [31:0] cause, pc;
        bit trap, irq;
        exp_q.delete();
        exp_jump = 0; exp_cyc = -1; exp_hold = 0; exp_ack = 0; exp_addr = 32'h0;
        trap = 1; irq = 0; cause = 0;
        if (ec)                 cause = 11;
        else if (eb)            cause = 3;
        else if (mr)            trap = 0;
        else if (ext && ms[3])  begin cause = 32'h8000_000B; irq = 1; end
        else if (tmr && ms[3])  begin cause = 32'h8000_0007; irq = 1; end
        else return;
        exp_jump = 1;
        if (trap) begin
            pc = (irq && jmp) ? ja : ia;
            exp_q.push_back({12'h341, pc});
            exp_q.push_back({12'h300, (ms & ~32'h88) | (ms[3] ? 32'h80 : 32'h0)});
            exp_q.push_back({12'h342, cause});
            exp_addr = mtv & ~32'h3;
`ifdef INTC_VECTORED_EN
            if (irq && (mtv % 4) == 1) exp_addr = exp_addr + (cause % 16) * 4;
`endif
            exp_cyc = 4; exp_hold = 5; exp_ack = irq ? 1 : 0;
        end else begin
            exp_q.push_back({12'h300, (ms & ~32'h88) | 32'h80 | (ms[7] ? 32'h8 : 32'h0)});
            exp_addr = mepc; exp_cyc = 2; exp_hold = 3;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        ecall_i = 0; ebreak_i = 0; mret_i = 0; ex_jump_i = 0; irq_ext_i = 0; irq_timer_i = 0;
        inst_addr_i = 0; ex_jump_addr_i = 0; csr_mtvec_i = 32'h200;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        n_total++; if (csr_intc_we_o !== 1'b0) $display("FAIL reset_we: got %b want 0", csr_intc_we_o); else n_pass++;
        n_total++; if (csr_intc_addr_o !== 12'h0) $display("FAIL reset_addr: got %h want 000", csr_intc_addr_o); else n_pass++;
        n_total++; if (csr_intc_data_o !== 32'h0) $display("FAIL reset_data: got %h want 0", csr_intc_data_o); else n_pass++;
        n_total++; if (int_jump_o !== 1'b0) $display("FAIL reset_jump: got %b want 0", int_jump_o); else n_pass++;
        n_total++; if (irq_ack_o !== 1'b0) $display("FAIL reset_ack: got %b want 0", irq_ack_o); else n_pass++;
        n_total++; if (int_addr_o !== 32'h0) $display("FAIL reset_int_addr: got %h want 0", int_addr_o); else n_pass++;
        n_total++; if (hold_flag_o !== 1'b0) $display("FAIL reset_hold: got %b want 0", hold_flag_o); else n_pass++;
    endtask

    task automatic test_ecall;
        sw_write(12'h300, 32'h8);
        csr_mtvec_i = 32'h200;
        run_seq(1, 0, 0, 0, 0, 0, 32'h100, 32'h0, 0);
        n_total++; if (wr_q.size() != 3) $display("FAIL ecall_nwr: got %0d want 3", wr_q.size()); else n_pass++;
        n_total++; if (wr_at(0) !== {12'h341, 32'h100}) $display("FAIL ecall_mepc: got %h want 34100000100", wr_at(0)); else n_pass++;
        n_total++; if (wr_at(1) !== {12'h300, 32'h80}) $display("FAIL ecall_mstatus: got %h want 30000000080", wr_at(1)); else n_pass++;
        n_total++; if (wr_at(2) !== {12'h342, 32'd11}) $display("FAIL ecall_mcause: got %h want 3420000000b", wr_at(2)); else n_pass++;
        n_total++; if (jump_cyc != 4 || jump_addr !== 32'h200) $display("FAIL ecall_jump: got cyc %0d addr %h want cyc 4 addr 200", jump_cyc, jump_addr); else n_pass++;
        n_total++; if (!hold0 || n_hold != 5) $display("FAIL ecall_hold: got hold0 %b cycles %0d want 1 and 5", hold0, n_hold); else n_pass++;
        n_total++; if (n_ack != 0) $display("FAIL ecall_ack: got %0d want 0", n_ack); else n_pass++;
        n_total++; if (int_addr_o !== 32'h200) $display("FAIL ecall_addr_hold: got %h want 200", int_addr_o); else n_pass++;
    endtask

    task automatic test_irq_mie;
        sw_write(12'h300, 32'h0);
        run_seq(0, 0, 0, 0, 1, 0, 32'h180, 32'h0, 1);
        n_total++; if (hold0 || wr_q.size() != 0 || n_ack != 0) $display("FAIL timer_masked: got hold %b writes %0d ack %0d want 0 0 0", hold0, wr_q.size(), n_ack); else n_pass++;
        sw_write(12'h300, 32'h8);
        run_seq(0, 0, 0, 0, 1, 0, 32'h180, 32'h0, 1);
        n_total++; if (wr_at(2) !== {12'h342, 32'h8000_0007}) $display("FAIL timer_mcause: got %h want 34280000007", wr_at(2)); else n_pass++;
        n_total++; if (n_ack != 1) $display("FAIL timer_ack: got %0d want 1", n_ack); else n_pass++;
        n_total++; if (wr_q.size() != 3 || n_hold != 5) $display("FAIL timer_once: got writes %0d hold %0d want 3 5", wr_q.size(), n_hold); else n_pass++;
    endtask

    task automatic test_irq_jump;
        sw_write(12'h300, 32'h8);
        run_seq(0, 0, 0, 1, 0, 1, 32'h300, 32'h400, 0);
        n_total++; if (wr_at(0) !== {12'h341, 32'h400}) $display("FAIL ext_mepc: got %h want 34100000400", wr_at(0)); else n_pass++;
        n_total++; if (wr_at(2) !== {12'h342, 32'h8000_000B}) $display("FAIL ext_mcause: got %h want 3428000000b", wr_at(2)); else n_pass++;
    endtask

    task automatic test_priority;
        sw_write(12'h300, 32'h8);
        run_seq(1, 0, 0, 1, 0, 0, 32'h120, 32'h0, 1);
        n_total++; if (wr_at(2) !== {12'h342, 32'd11} || n_ack != 0) $display("FAIL prio_ecall: got %h ack %0d want 3420000000b ack 0", wr_at(2), n_ack); else n_pass++;
        n_total++; if (wr_q.size() != 3) $display("FAIL prio_no_retake: got %0d writes want 3", wr_q.size()); else n_pass++;
        run_seq(0, 0, 0, 1, 0, 0, 32'h124, 32'h0, 0);
        n_total++; if (hold0 || wr_q.size() != 0) $display("FAIL prio_masked: got hold %b writes %0d want 0 0", hold0, wr_q.size()); else n_pass++;
        sw_write(12'h300, 32'h8);
        run_seq(0, 0, 0, 1, 0, 0, 32'h124, 32'h0, 0);
        n_total++; if (wr_at(2) !== {12'h342, 32'h8000_000B} || n_ack != 1) $display("FAIL prio_irq_later: got %h ack %0d want 3428000000b ack 1", wr_at(2), n_ack); else n_pass++;
    endtask

    task automatic test_mret;
        sw_write(12'h300, 32'h80);
        sw_write(12'h341, 32'h104);
        run_seq(0, 0, 1, 0, 0, 0, 32'h140, 32'h0, 0);
        n_total++; if (wr_q.size() != 1 || wr_at(0) !== {12'h300, 32'h88}) $display("FAIL mret_write: got n %0d %h want 1 30000000088", wr_q.size(), wr_at(0)); else n_pass++;
        n_total++; if (jump_cyc != 2 || jump_addr !== 32'h104) $display("FAIL mret_jump: got cyc %0d addr %h want 2 104", jump_cyc, jump_addr); else n_pass++;
        n_total++; if (n_hold != 3) $display("FAIL mret_hold: got %0d want 3", n_hold); else n_pass++;
    endtask

`ifdef INTC_VECTORED_EN
    task automatic test_vectored;
        sw_write(12'h300, 32'h8);
        csr_mtvec_i = 32'h201;
        run_seq(0, 0, 0, 0, 1, 0, 32'h150, 32'h0, 0);
        n_total++; if (jump_addr !== 32'h21C) $display("FAIL vec_timer: got %h want 21c", jump_addr); else n_pass++;
        sw_write(12'h300, 32'h8);
        run_seq(1, 0, 0, 0, 0, 0, 32'h150, 32'h0, 0);
        n_total++; if (jump_addr !== 32'h200) $display("FAIL vec_exc_base: got %h want 200", jump_addr); else n_pass++;
        csr_mtvec_i = 32'h200;
    endtask
`endif

    task automatic test_random;
        for (int i = 0; i < 40; i++) begin
            bit ec, eb, mr, ext, tmr, jmp;
            logic [31:0] ia, ja, ms, mp, mtv;
            ec  = ($urandom_range(0, 9) < 2); eb = ($urandom_range(0, 9) < 2);
            mr  = ($urandom_range(0, 9) < 3); ext = ($urandom_range(0, 9) < 4);
            tmr = ($urandom_range(0, 9) < 4); jmp = $urandom_range(0, 1);
            ia = $urandom & ~32'h3; ja = $urandom & ~32'h3;
            ms = $urandom; mp = $urandom & ~32'h3; mtv = $urandom;
            sw_write(12'h300, ms);
            sw_write(12'h341, mp);
            csr_mtvec_i = mtv;
            model(ec, eb, mr, ext, tmr, jmp, ia, ja, ms, mp, mtv);
            run_seq(ec, eb, mr, ext, tmr, jmp, ia, ja, 0);
            n_total++; if (wr_q.size() != exp_q.size()) $display("FAIL rnd%0d_nwr: got %0d want %0d", i, wr_q.size(), exp_q.size()); else n_pass++;
            for (int k = 0; k < exp_q.size(); k++) begin
                n_total++; if (wr_at(k) !== exp_q[k]) $display("FAIL rnd%0d_wr%0d: got %h want %h", i, k, wr_at(k), exp_q[k]); else n_pass++;
            end
            n_total++; if (n_jump != exp_jump || jump_cyc != exp_cyc) $display("FAIL rnd%0d_jump: got n %0d cyc %0d want n %0d cyc %0d", i, n_jump, jump_cyc, exp_jump, exp_cyc); else n_pass++;
            if (exp_jump == 1) begin
                n_total++; if (jump_addr !== exp_addr) $display("FAIL rnd%0d_target: got %h want %h", i, jump_addr, exp_addr); else n_pass++;
            end
            n_total++; if (n_hold != exp_hold || hold0 != (exp_hold > 0)) $display("FAIL rnd%0d_hold: got %0d/%b want %0d", i, n_hold, hold0, exp_hold); else n_pass++;
            n_total++; if (n_ack != exp_ack) $display("FAIL rnd%0d_ack: got %0d want %0d", i, n_ack, exp_ack); else n_pass++;
        end
        csr_mtvec_i = 32'h200;
    endtask

    task automatic test_reset_mid;
        int nwe;
        sw_write(12'h300, 32'h8);
        ecall_i = 1; inst_addr_i = 32'h100;
        @(posedge clk); #1 ecall_i = 0;
        @(posedge clk); #1;
        @(negedge clk);
        n_total++; if (csr_intc_we_o !== 1'b1 || csr_intc_addr_o !== 12'h300) $display("FAIL mid_in_mstatus: got we %b addr %h want 1 300", csr_intc_we_o, csr_intc_addr_o); else n_pass++;
        rst_n = 1'b0;
        #1;
        n_total++; if ({csr_intc_we_o, int_jump_o, irq_ack_o, hold_flag_o} !== 4'b0) $display("FAIL mid_reset_ctl: got %b want 0000", {csr_intc_we_o, int_jump_o, irq_ack_o, hold_flag_o}); else n_pass++;
        n_total++; if (csr_intc_addr_o !== 12'h0 || csr_intc_data_o !== 32'h0 || int_addr_o !== 32'h0) $display("FAIL mid_reset_bus: got %h %h %h want 0 0 0", csr_intc_addr_o, csr_intc_data_o, int_addr_o); else n_pass++;
        @(posedge clk); #1 rst_n = 1'b1;
        nwe = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (csr_intc_we_o || int_jump_o || hold_flag_o) nwe++;
        end
        n_total++; if (nwe != 0) $display("FAIL mid_no_resume: got %0d active cycles want 0", nwe); else n_pass++;
        n_total++; if (csr_mepc_i !== 32'h100) $display("FAIL mid_partial_kept: got %h want 100", csr_mepc_i); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_ecall();
        test_irq_mie();
        test_irq_jump();
        test_priority();
        test_mret();
`ifdef INTC_VECTORED_EN
        test_vectored();
`endif
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
